// File: rtl/axi4_slave_mem_pkg.sv
// Shared AXI parameters, burst/response encodings and FSM state types
// for the AXI4 slave memory.
package axi_parameters;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_DEPTH  = 1024;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_t;

endpackage

// File: rtl/axi4_slave_mem_addr_gen.sv
// Combinational next-beat address and per-beat error flag for one burst.
// Covers FIXED/INCR/WRAP stepping plus illegal burst, wrap length, size
// and out-of-range word checks.
module axi_addr_gen
  import axi_parameters::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic [AW-1:0] addr,
  input  logic [3:0]    len,
  input  logic [2:0]    size,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr,
  output logic          err
);

  localparam int WB = $clog2(DW / 8);

  logic [AW-1:0] step;
  logic [AW-1:0] span;
  logic [AW-1:0] mask;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] word_idx;
  logic          wrap_len_ok;

  // Step the address and flag any condition that makes this beat an error
  always_comb begin
    step        = AW'(1) << size;
    span        = AW'({1'b0, len} + 5'd1) << size;
    mask        = span - AW'(1);
    incr_addr   = addr + step;
    word_idx    = addr >> WB;
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    next_addr   = addr;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      // Upper bits stay in the aligned window, low bits roll over
      BURST_WRAP: next_addr = (addr & ~mask) | (incr_addr & mask);
      default:    next_addr = addr;
    endcase
    err = (burst == 2'b11)
       || ((burst == BURST_WRAP) && !wrap_len_ok)
       || (size > 3'(WB))
       || (word_idx >= AW'(DEPTH));
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave terminating FIXED/INCR/WRAP bursts into a word-addressed RAM.
// Independent write (AW->W->B) and read (AR->R) FSMs, one outstanding
// transaction each. All handshake outputs are registered.
module axi4_slave_mem
  import axi_parameters::*;
#(
  parameter int ADDR_WIDTH = axi_parameters::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_parameters::DATA_WIDTH,
  parameter int MEM_DEPTH  = axi_parameters::MEM_DEPTH
) (
  input  logic                    clk,
  input  logic                    ARESET_n,
  input  logic [8:0]              AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [3:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [8:0]              WID,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [8:0]              BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [8:0]              ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [3:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [8:0]              RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int WB = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int SW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------- write path ----------------
  wr_state_t             wr_state;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_next, wr_word;
  logic [3:0]            wr_len, wr_cnt;
  logic [2:0]            wr_size;
  logic [1:0]            wr_burst;
  logic                  wr_err, wr_gen_err, wr_last_exp, wr_beat_err, w_fire;
  logic [IW-1:0]         wr_idx;

  axi_addr_gen #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(MEM_DEPTH)) u_wr_gen (
    .addr(wr_addr), .len(wr_len), .size(wr_size), .burst(wr_burst),
    .next_addr(wr_next), .err(wr_gen_err)
  );

  assign w_fire      = WVALID && WREADY;
  assign wr_last_exp = (wr_cnt == wr_len);
  // A WLAST that disagrees with the beat count poisons that beat as well
  assign wr_beat_err = wr_gen_err || (WLAST != wr_last_exp);
  assign wr_word     = wr_addr >> WB;
  assign wr_idx      = wr_word[IW-1:0];

  // Byte-enabled RAM write; erroring beats never touch the array
  always_ff @(posedge clk) begin
    if (w_fire && !wr_beat_err) begin
      for (int b = 0; b < SW; b++) begin
        if (WSTRB[b]) mem[wr_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  // Write FSM: accept AW, absorb W beats, hold B until taken
  always_ff @(posedge clk or negedge ARESET_n) begin
    if (!ARESET_n) begin
      wr_state <= WR_IDLE;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BID      <= '0;
      BRESP    <= '0;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_size  <= '0;
      wr_burst <= '0;
      wr_cnt   <= '0;
      wr_err   <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (AWVALID && AWREADY) begin
            AWREADY  <= 1'b0;
            WREADY   <= 1'b1;
            BID      <= AWID;
            wr_addr  <= AWADDR;
            wr_len   <= AWLEN;
            wr_size  <= AWSIZE;
            wr_burst <= AWBURST;
            wr_cnt   <= '0;
            wr_err   <= 1'b0;
            wr_state <= WR_DATA;
          end else begin
            AWREADY <= 1'b1;
          end
        end
        WR_DATA: begin
          if (w_fire) begin
            wr_addr <= wr_next;
            wr_cnt  <= wr_cnt + 4'd1;
            wr_err  <= wr_err || wr_beat_err;
            if (wr_last_exp) begin
              WREADY   <= 1'b0;
              BVALID   <= 1'b1;
              BRESP    <= (wr_err || wr_beat_err) ? RESP_SLVERR : RESP_OKAY;
              wr_state <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (BREADY) begin
            BVALID   <= 1'b0;
            AWREADY  <= 1'b1;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rd_state_t             rd_state;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_gen_addr, rd_next, rd_word;
  logic [3:0]            rd_len, rd_gen_len, rd_cnt;
  logic [2:0]            rd_size, rd_gen_size;
  logic [1:0]            rd_burst, rd_gen_burst;
  logic                  rd_gen_err;
  logic [IW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_beat_data;

  // In idle the generator looks at the AR fields so beat 0 loads on the
  // handshake edge; afterwards it walks the latched burst. rd_addr always
  // holds the address of the next beat to load.
  assign rd_gen_addr  = (rd_state == RD_IDLE) ? ARADDR  : rd_addr;
  assign rd_gen_len   = (rd_state == RD_IDLE) ? ARLEN   : rd_len;
  assign rd_gen_size  = (rd_state == RD_IDLE) ? ARSIZE  : rd_size;
  assign rd_gen_burst = (rd_state == RD_IDLE) ? ARBURST : rd_burst;

  axi_addr_gen #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(MEM_DEPTH)) u_rd_gen (
    .addr(rd_gen_addr), .len(rd_gen_len), .size(rd_gen_size), .burst(rd_gen_burst),
    .next_addr(rd_next), .err(rd_gen_err)
  );

  assign rd_word      = rd_gen_addr >> WB;
  assign rd_idx       = rd_word[IW-1:0];
  // Same-edge write is non-blocking, so this sees the old word
  assign rd_beat_data = rd_gen_err ? '0 : mem[rd_idx];

  // Read FSM: registered R channel, next beat loaded on each R handshake
  always_ff @(posedge clk or negedge ARESET_n) begin
    if (!ARESET_n) begin
      rd_state <= RD_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RID      <= '0;
      RDATA    <= '0;
      RRESP    <= '0;
      RLAST    <= 1'b0;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_size  <= '0;
      rd_burst <= '0;
      rd_cnt   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ARVALID && ARREADY) begin
            ARREADY  <= 1'b0;
            RVALID   <= 1'b1;
            RID      <= ARID;
            RDATA    <= rd_beat_data;
            RRESP    <= rd_gen_err ? RESP_SLVERR : RESP_OKAY;
            RLAST    <= (ARLEN == 4'd0);
            rd_addr  <= rd_next;
            rd_len   <= ARLEN;
            rd_size  <= ARSIZE;
            rd_burst <= ARBURST;
            rd_cnt   <= '0;
            rd_state <= RD_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        RD_DATA: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID   <= 1'b0;
              ARREADY  <= 1'b1;
              rd_state <= RD_IDLE;
            end else begin
              RDATA   <= rd_beat_data;
              RRESP   <= rd_gen_err ? RESP_SLVERR : RESP_OKAY;
              RLAST   <= ((rd_cnt + 4'd1) == rd_len);
              rd_cnt  <= rd_cnt + 4'd1;
              rd_addr <= rd_next;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // WID carries no meaning here; high address bits are covered by the range check
  logic unused;
  assign unused = ^{WID, wr_word[ADDR_WIDTH-1:IW], rd_word[ADDR_WIDTH-1:IW]};

endmodule
